paramcpu: RTL and testbench
===========================

PARAMCPU -- requirements
Module: paramcpu

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data and instruction word width; legal only if DATA_W >= ADDR_W+4.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning RAM address width; RAM depth is 2**ADDR_W words.
REQ-003 The block SHALL have port clk, input, 1, clock.
REQ-004 The block SHALL have port reset, input, 1, reset; synchronous, active-low.
REQ-005 The block SHALL have port load_ram, input, 1, RAM write strobe, honoured only while reset is low.
REQ-006 The block SHALL have port load_addr, input, ADDR_W, RAM write address.
REQ-007 The block SHALL have port load_data, input, DATA_W, RAM write data.
REQ-008 The block SHALL have port out_data, output, DATA_W, output register value.
REQ-009 The block SHALL have port out_valid, output, 1, out_data holds an unconsumed OUT value.
REQ-010 The block SHALL have port out_ready, input, 1, sink accepts out_data.
REQ-011 The block SHALL have port halted, output, 1, the CPU is in HALT.
REQ-012 The block SHALL have port pc, output, ADDR_W, current program counter.

Function
REQ-013 Instruction format SHALL be: opcode = word[DATA_W-1:DATA_W-4]; operand = word[ADDR_W-1:0]; all other bits ignored.
REQ-014 Opcodes SHALL be: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JZ, 8 OUT, 9 HLT; undefined opcodes SHALL execute as NOP.
REQ-015 The state machine SHALL have states FETCH, DECODE, EXECUTE, OUTWAIT and HALT: FETCH->DECODE->EXECUTE->FETCH; HLT goes EXECUTE->HALT; OUT goes EXECUTE->OUTWAIT.
REQ-016 Every non-OUT, non-HLT instruction SHALL take exactly 3 cycles (FETCH, DECODE, EXECUTE).
REQ-017 FETCH SHALL register ram[pc]; DECODE SHALL register ram[operand] into B for LDA, ADD and SUB; EXECUTE SHALL commit results and update pc.
REQ-018 PC SHALL increment modulo 2**ADDR_W, so the last address wraps to 0.
REQ-019 ADD and SUB SHALL produce a DATA_W-bit result modulo 2**DATA_W, written to A.
REQ-020 Carry SHALL be the carry-out for ADD and the borrow (A<B unsigned) for SUB.
REQ-021 The Z and C flags SHALL be registered, updated only by ADD/SUB, and reset to 0.
REQ-022 JZ and the conditional jumps SHALL test the flags registered before the jump is fetched.
REQ-023 LDI SHALL zero-extend the operand to DATA_W.
REQ-024 STA SHALL write A to ram[operand] in EXECUTE.
REQ-025 OUT SHALL load A into out_data and set out_valid.
REQ-026 In OUTWAIT, out_valid SHALL stay high with out_data stable until out_ready is high on a clock edge; that edge SHALL clear out_valid, increment pc and enter FETCH.
REQ-027 If out_ready is already high when OUT executes, the value SHALL be consumed on the next edge, giving a 4-cycle OUT minimum.
REQ-028 HALT SHALL be a sink state in which no register changes, halted=1, and out_valid is held if set.
REQ-029 Loads SHALL occur only during reset, so an STA and a load can never collide.

Reset
REQ-030 While reset is low: pc=0, A=0, B=0, Z=0, C=0, out_data=0, out_valid=0, halted=0, state=FETCH; RAM content is retained apart from loads.
REQ-031 Reset asserted mid-instruction or mid-OUTWAIT SHALL abort the instruction with no partial RAM write and SHALL drop out_valid.

Configuration
REQ-032 With PARAMCPU_CONDJMP_EN defined, opcodes A (JC: jump if C) and B (JNZ: jump if !Z) SHALL be implemented.
REQ-033 Without PARAMCPU_CONDJMP_EN, opcodes A and B SHALL execute as NOP.

Structure
REQ-034 Package paramcpu_pkg SHALL hold the opcode constants and the state-encoding typedef.
REQ-035 Sub-module paramcpu_alu (parametrised DATA_W; a, b, sub in; result, zero, carry out; combinational) SHALL implement ADD/SUB.

Verification
REQ-036 Load {LDA 14, ADD 15, OUT, HLT} with ram[14]=5 and ram[15]=7, out_ready=1 -> out_data=12, out_valid pulses once, halted=1.
REQ-037 LDI 3; SUB from ram holding 3; JZ 6; path at 6 outputs 0xAA -> Z=1, the jump is taken, and out_data=0xAA.
REQ-038 OUT with out_ready=0 for 5 cycles -> out_valid held and pc frozen; out_ready=1 -> accepted on one edge and pc advances.
REQ-039 Program of 16 NOPs, ADDR_W=4 -> pc wraps from 15 to 0; each instruction takes 3 cycles.
REQ-040 DATA_W=8: 0xFF+0x01 -> A=0, Z=1, C=1; 0x02-0x03 -> A=0xFF, C=1; with the macro, JC is taken; without it, JC acts as NOP.
REQ-041 Reset pulsed during OUTWAIT -> out_valid=0, pc=0, RAM is unchanged, and the program reruns.

Source files
------------

// File: rtl/paramcpu_pkg.sv
// paramcpu_pkg: shared definitions for the paramcpu accumulator CPU.
//   - 4-bit opcode constants (top nibble of each instruction word)
//   - state_t: controller state encoding
//   - reads_operand(): opcodes whose DECODE cycle fetches ram[operand] into B
package paramcpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'h8;
    localparam logic [3:0] OP_HLT = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_JNZ = 4'hB;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_OUTWAIT,
        ST_HALT
    } state_t;

    function automatic logic reads_operand(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/paramcpu_alu.sv
// paramcpu_alu: combinational adder/subtractor.
//   a, b    : operands (DATA_W)
//   sub     : 0 = a+b, 1 = a-b
//   result  : DATA_W-bit result modulo 2**DATA_W
//   zero    : result == 0
//   carry   : carry-out for add, borrow (a < b unsigned) for subtract
module paramcpu_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    logic [DATA_W:0] w_wide;

    // One extra bit: for subtraction the top bit of the widened
    // difference is exactly the unsigned borrow.
    always_comb begin
        if (sub) begin
            w_wide = {1'b0, a} - {1'b0, b};
        end else begin
            w_wide = {1'b0, a} + {1'b0, b};
        end
        result = w_wide[DATA_W-1:0];
        carry  = w_wide[DATA_W];
        zero   = (w_wide[DATA_W-1:0] == '0);
    end

endmodule

// File: rtl/paramcpu.sv
// paramcpu: multi-cycle accumulator CPU with on-chip RAM.
//   clk, reset      : clock; synchronous active-low reset
//   load_ram/addr/  : RAM write port, honoured only while reset is low
//   load_data
//   out_data/valid  : OUT value with valid/ready handshake (out_ready in)
//   halted          : CPU sits in HALT
//   pc              : current program counter
// Optional feature: define PARAMCPU_CONDJMP_EN to enable JC (0xA) and
// JNZ (0xB); otherwise those opcodes behave as NOP.
module paramcpu
    import paramcpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_ram,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

`ifdef PARAMCPU_CONDJMP_EN
    localparam bit CONDJMP_EN = 1'b1;
`else
    localparam bit CONDJMP_EN = 1'b0;
`endif

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_ram [2**ADDR_W];
    logic [3:0]        r_op;
    logic [ADDR_W-1:0] r_opd;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_z;
    logic              r_c;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_pc;

    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_zero;
    logic              w_alu_carry;
    logic              w_jump;
    logic [ADDR_W-1:0] w_pc_inc;

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign pc        = r_pc;
    assign halted    = (r_state == ST_HALT);
    assign w_pc_inc  = r_pc + ADDR_W'(1);

    paramcpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (r_a),
        .b      (r_b),
        .sub    (r_op == OP_SUB),
        .result (w_alu_res),
        .zero   (w_alu_zero),
        .carry  (w_alu_carry)
    );

    // Flags are those registered by an earlier ADD/SUB, never the
    // current instruction's.
    always_comb begin
        w_jump = 1'b0;
        case (r_op)
            OP_JMP:  w_jump = 1'b1;
            OP_JZ:   w_jump = r_z;
            OP_JC:   w_jump = CONDJMP_EN && r_c;
            OP_JNZ:  w_jump = CONDJMP_EN && !r_z;
            default: w_jump = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:   w_next = ST_DECODE;
            ST_DECODE:  w_next = ST_EXECUTE;
            ST_EXECUTE: begin
                if (r_op == OP_OUT) begin
                    w_next = ST_OUTWAIT;
                end else if (r_op == OP_HLT) begin
                    w_next = ST_HALT;
                end else begin
                    w_next = ST_FETCH;
                end
            end
            ST_OUTWAIT: if (out_ready) w_next = ST_FETCH;
            ST_HALT:    w_next = ST_HALT;
            default:    w_next = ST_FETCH;
        endcase
    end

    // Datapath. OUT and HLT leave pc on their own address; OUT advances
    // it when the sink accepts the value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op        <= '0;
            r_opd       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_pc        <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_op  <= r_ram[r_pc][DATA_W-1 -: 4];
                    r_opd <= r_ram[r_pc][ADDR_W-1:0];
                end
                ST_DECODE: begin
                    if (reads_operand(r_op)) r_b <= r_ram[r_opd];
                end
                ST_EXECUTE: begin
                    r_pc <= w_jump ? r_opd : w_pc_inc;
                    case (r_op)
                        OP_LDA: r_a <= r_b;
                        OP_ADD, OP_SUB: begin
                            r_a <= w_alu_res;
                            r_z <= w_alu_zero;
                            r_c <= w_alu_carry;
                        end
                        OP_LDI: r_a <= {{(DATA_W-ADDR_W){1'b0}}, r_opd};
                        OP_OUT: begin
                            r_out_data  <= r_a;
                            r_out_valid <= 1'b1;
                            r_pc        <= r_pc;
                        end
                        OP_HLT: r_pc <= r_pc;
                        default: ;
                    endcase
                end
                ST_OUTWAIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_pc        <= w_pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM has no reset: contents survive reset, loads happen only then,
    // so loads and STA never contend.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (load_ram) r_ram[load_addr] <= load_data;
        end else if (r_state == ST_EXECUTE && r_op == OP_STA) begin
            r_ram[r_opd] <= r_a;
        end
    end

endmodule

// File: tb/tb_paramcpu.sv
module tb_paramcpu;

    typedef logic [7:0] img_t [16];

`ifdef PARAMCPU_CONDJMP_EN
    localparam bit CJ = 1'b1;
`else
    localparam bit CJ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_ram = 1'b0;
    logic [3:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       halted;
    logic [3:0] pc;

    paramcpu #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .load_ram  (load_ram),
        .load_addr (load_addr),
        .load_data (load_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .halted    (halted),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction-level reference: each instruction's whole effect is
    // applied on its third clock after it starts; OUT then waits for an
    // accepting edge.
    logic [7:0] m_ram [16];
    logic [3:0] m_pc;
    int         m_a, m_out;
    bit         m_z, m_c, m_valid, m_halt, m_wait, m_known = 1'b0;
    int         m_cnt;

    task automatic m_exec();
        logic [7:0] w;
        logic [3:0] op, opd, nxt;
        int b, s;
        w   = m_ram[m_pc];
        op  = w[7:4];
        opd = w[3:0];
        nxt = m_pc + 4'd1;
        b   = m_ram[opd];
        case (op)
            4'h1: m_a = b;
            4'h2: begin s = m_a + b; m_c = (s > 255); m_a = s % 256; m_z = (m_a == 0); end
            4'h3: begin m_c = (m_a < b); m_a = (m_a - b + 256) % 256; m_z = (m_a == 0); end
            4'h4: m_ram[opd] = 8'(m_a);
            4'h5: m_a = opd;
            4'h6: nxt = opd;
            4'h7: if (m_z) nxt = opd;
            4'h8: begin m_out = m_a; m_valid = 1'b1; m_wait = 1'b1; nxt = m_pc; end
            4'h9: begin m_halt = 1'b1; nxt = m_pc; end
            4'hA: if (CJ && m_c) nxt = opd;
            4'hB: if (CJ && !m_z) nxt = opd;
            default: ;
        endcase
        m_pc = nxt;
    endtask

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            m_pc = '0; m_a = 0; m_z = 0; m_c = 0; m_out = 0;
            m_valid = 0; m_halt = 0; m_wait = 0; m_cnt = 0;
            if (load_ram) m_ram[load_addr] = load_data;
            m_known = 1'b1;
        end else if (m_halt) begin
        end else if (m_wait) begin
            if (out_ready) begin
                m_valid = 1'b0;
                m_wait  = 1'b0;
                m_pc    = m_pc + 4'd1;
            end
        end else begin
            m_cnt++;
            if (m_cnt == 3) begin
                m_cnt = 0;
                m_exec();
            end
        end
        if (m_known) begin
            chk("pc", int'(pc), int'(m_pc));
            chk("halted", int'(halted), int'(m_halt));
            chk("out_valid", int'(out_valid), int'(m_valid));
            chk("out_data", int'(out_data), m_out);
        end
    end

    logic [7:0] outs [$];
    bit rand_ready = 1'b0;

    task automatic cycle();
        @(negedge clk);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) outs.push_back(out_data);
    endtask

    task automatic load_prog(input img_t img);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            load_ram  = 1'b1;
            load_addr = 4'(i);
            load_data = img[i];
            @(negedge clk);
        end
        load_ram = 1'b0;
        reset    = 1'b1;
        outs.delete();
    endtask

    task automatic run_to_halt(input int limit, output int n);
        n = 0;
        while (n < limit && !halted) begin
            cycle();
            n++;
        end
        chk("halt_reached", int'(halted), 1);
    endtask

    task automatic wait_valid(input int limit);
        int n;
        n = 0;
        while (n < limit && !out_valid) begin
            cycle();
            n++;
        end
        chk("valid_reached", int'(out_valid), 1);
    endtask

    task automatic chk_out(input string name, input int idx, input int exp);
        if (outs.size() > idx) chk(name, int'(outs[idx]), exp);
        else chk(name, -1, exp);
    endtask

    initial begin
        img_t img;
        int   n;

        // Two-operand add, then OUT with ready high, then halt.
        img = '{default: 8'h00};
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'h80; img[3] = 8'h90;
        img[14] = 8'd5; img[15] = 8'd7;
        out_ready = 1'b1;
        load_prog(img);
        chk("reset_pc", int'(pc), 0);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_data", int'(out_data), 0);
        run_to_halt(60, n);
        chk("add_cycles", n, 13);
        chk("add_nouts", outs.size(), 1);
        chk_out("add_out", 0, 12);
        chk("add_pc", int'(pc), 3);

        // SUB to zero, JZ taken to 6, output 0xAA.
        img = '{default: 8'h00};
        img[0] = 8'h53; img[1] = 8'h3F; img[2] = 8'h76; img[3] = 8'h90;
        img[6] = 8'h1E; img[7] = 8'h80; img[8] = 8'h90;
        img[14] = 8'hAA; img[15] = 8'h03;
        load_prog(img);
        run_to_halt(80, n);
        chk("jz_cycles", n, 19);
        chk("jz_nouts", outs.size(), 1);
        chk_out("jz_out", 0, 8'hAA);
        chk("jz_pc", int'(pc), 8);

        // Backpressured OUT.
        img = '{default: 8'h00};
        img[0] = 8'h55; img[1] = 8'h80; img[2] = 8'h90;
        out_ready = 1'b0;
        load_prog(img);
        wait_valid(20);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_pc", int'(pc), 1);
            chk("bp_data", int'(out_data), 5);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_accept_valid", int'(out_valid), 0);
        chk("bp_accept_pc", int'(pc), 2);
        run_to_halt(20, n);

        // 16 NOPs: pc wraps, 3 cycles each.
        img = '{default: 8'h00};
        load_prog(img);
        for (int k = 0; k < 45; k++) cycle();
        chk("wrap_pc45", int'(pc), 15);
        cycle(); cycle();
        chk("wrap_pc47", int'(pc), 15);
        cycle();
        chk("wrap_pc48", int'(pc), 0);

        // Carry/borrow corner cases and JC.
        img = '{default: 8'h00};
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'h74; img[3] = 8'h90;
        img[4] = 8'h80; img[5] = 8'h52; img[6] = 8'h3D; img[7] = 8'h80;
        img[8] = 8'hAB; img[9] = 8'h55; img[10] = 8'h80; img[11] = 8'h90;
        img[13] = 8'h03; img[14] = 8'hFF; img[15] = 8'h01;
        load_prog(img);
        run_to_halt(120, n);
        chk("cy_nouts", outs.size(), CJ ? 2 : 3);
        chk_out("cy_add_out", 0, 8'h00);
        chk_out("cy_sub_out", 1, 8'hFF);
        if (!CJ) chk_out("cy_jc_nop_out", 2, 8'h05);
        chk("cy_pc", int'(pc), 11);

        // Reset during OUTWAIT; program reruns from retained RAM.
        img = '{default: 8'h00};
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'h80; img[3] = 8'h90;
        img[14] = 8'd5; img[15] = 8'd7;
        out_ready = 1'b0;
        load_prog(img);
        wait_valid(20);
        reset = 1'b0;
        cycle();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_pc", int'(pc), 0);
        chk("rst_halted", int'(halted), 0);
        reset = 1'b1;
        out_ready = 1'b1;
        outs.delete();
        run_to_halt(60, n);
        chk("rst_nouts", outs.size(), 1);
        chk_out("rst_out", 0, 12);

        // Random programs, random backpressure, occasional mid-run reset.
        rand_ready = 1'b1;
        for (int p = 0; p < 14; p++) begin
            for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
            load_prog(img);
            for (int c = 0; c < 200 && !halted; c++) begin
                cycle();
                if (p % 3 == 0 && c == 37) begin
                    reset = 1'b0;
                    cycle();
                    reset = 1'b1;
                end
            end
            for (int k = 0; k < 4; k++) cycle();
        end
        rand_ready = 1'b0;

        cycle(); cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
